// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/result and shifter return-path bundle for shift_sequencer
interface shift_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
);
    logic             start;
    logic [1:0]       op;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] sh_in;
    logic [1:0]       sh_ctl;
    logic [WIDTH-1:0] sh_out;

    // The master side owns the request and hosts the combinational shifter.
    modport master (
        output start, op, amt, din, sh_out,
        input  busy, done, dout, sh_in, sh_ctl
    );

    modport slave (
        input  start, op, amt, din, sh_out,
        output busy, done, dout, sh_in, sh_ctl
    );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - iterates a single-position shifter to build variable-distance shifts
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    shift_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_dout;
    logic [AMT_W-1:0] r_cnt;
    logic [1:0]       r_opr;
    logic             w_accept;
    logic [1:0]       w_sh_ctl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_sh_ctl = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    // A pass op or zero distance has nothing to iterate.
                    if (bus.amt == '0 || bus.op == 2'b00) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_sh_ctl = r_opr;
                if (r_cnt == AMT_W'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_opr  <= 2'b00;
            r_dout <= '0;
        end else begin
            if (w_accept) begin
                r_acc <= bus.din;
                r_cnt <= bus.amt;
                r_opr <= bus.op;
            end else if (r_state == S_RUN) begin
                r_acc <= bus.sh_out;
                r_cnt <= r_cnt - AMT_W'(1);
            end
            // Capture the value the accumulator takes on the same edge that enters DONE.
            if (w_next == S_DONE && r_state != S_DONE) begin
                r_dout <= (r_state == S_RUN) ? bus.sh_out : bus.din;
            end
        end
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.dout   = r_dout;
    assign bus.sh_in  = r_acc;
    assign bus.sh_ctl = w_sh_ctl;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer with a behavioural shifter
module tb_shift_sequencer;
    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always_comb begin
        case (bus.sh_ctl)
            2'b01:   bus.sh_out = {bus.sh_in[WIDTH-2:0], 1'b0};
            2'b10:   bus.sh_out = {1'b0, bus.sh_in[WIDTH-1:1]};
            2'b11:   bus.sh_out = {bus.sh_in[WIDTH-1], bus.sh_in[WIDTH-1:1]};
            default: bus.sh_out = bus.sh_in;
        endcase
    end

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_dout = '0;

    task automatic check_idle_regs(input string name);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dout !== 16'h0000 || bus.sh_ctl !== 2'b00) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b dout=%h sh_ctl=%b, required 0 0 0000 00",
                     name, bus.busy, bus.done, bus.dout, bus.sh_ctl);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [AMT_W-1:0] amt,
                          input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] expv,
                          input string name);
        int n, lat, shc, busyc;
        logic seen, ctl_bad, hold_bad;
        logic [WIDTH-1:0] want;
        n = (op == 2'b00 || amt == '0) ? 0 : int'(amt);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.amt = amt; bus.din = din;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op = 2'($urandom); bus.amt = AMT_W'($urandom); bus.din = WIDTH'($urandom);
        lat = 0; shc = 0; busyc = 0; seen = 1'b0; ctl_bad = 1'b0; hold_bad = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busyc++;
            if (bus.sh_ctl != 2'b00) begin
                shc++;
                if (bus.sh_ctl !== op) ctl_bad = 1'b1;
            end
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                want = exp_q.pop_front();
                checks++;
                if (bus.dout !== want) begin
                    errors++;
                    $display("FAIL %s dout: got %h, required %h", name, bus.dout, want);
                end
                last_dout = want;
            end else if (bus.dout !== last_dout) begin
                hold_bad = 1'b1;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles, required %0d", name, lat, n + 1);
            exp_q.delete();
        end
        checks++;
        if (lat != n + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d, required %0d", name, lat, n + 1);
        end
        checks++;
        if (busyc != n + 1) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d, required %0d", name, busyc, n + 1);
        end
        checks++;
        if (shc != n || ctl_bad) begin
            errors++;
            $display("FAIL %s sh_ctl: active %0d cycles (wrong code %b), required %0d cycles of %b",
                     name, shc, ctl_bad, n, op);
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL %s dout hold: changed before done, required %h", name, last_dout);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after done: done=%b busy=%b, required 0 0", name, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.op = 2'b00; bus.amt = '0; bus.din = '0;
        repeat (2) @(negedge clk);
        check_idle_regs("reset_held");
        reset_n = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.amt = 4'd4; bus.din = 16'h000F;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_idle_regs("reset_midcycle");
        @(negedge clk);
        reset_n = 1'b1;
        last_dout = '0;
    endtask

    task automatic test_left();
        run_op(2'b01, 4'd4, 16'h000F, 16'h00F0, "left4");
    endtask

    task automatic test_arith_right();
        run_op(2'b11, 4'd3, 16'hE381, 16'hFC70, "asr_neg");
        run_op(2'b11, 4'd3, 16'h03FF, 16'h007F, "asr_pos");
    endtask

    task automatic test_max_amt();
        run_op(2'b10, 4'd15, 16'h8000, 16'h0001, "lsr15");
        run_op(2'b01, 4'd15, 16'h0001, 16'h8000, "lsl15");
    endtask

    task automatic test_zero_len();
        run_op(2'b01, 4'd0, 16'h1234, 16'h1234, "amt0");
        run_op(2'b00, 4'd7, 16'hBEEF, 16'hBEEF, "pass");
    endtask

    task automatic test_interference();
        int cyc, dones;
        logic [WIDTH-1:0] want;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.amt = 4'd6; bus.din = 16'h0003;
        exp_q.push_back(16'h00C0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        dones = 0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin
                bus.start = 1'b1; bus.op = 2'b10; bus.amt = 4'd2; bus.din = 16'hFFFF;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                dones++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ignore_start: unexpected extra done, dout=%h", bus.dout);
                end else begin
                    want = exp_q.pop_front();
                    if (bus.dout !== want) begin
                        errors++;
                        $display("FAIL ignore_start dout: got %h, required %h", bus.dout, want);
                    end
                    last_dout = want;
                end
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL ignore_start done count: got %0d, required 1", dones);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.dout !== 16'h00C0) begin
            errors++;
            $display("FAIL ignore_start final: busy=%b dout=%h, required 0 00c0", bus.busy, bus.dout);
        end
        exp_q.delete();
    endtask

    task automatic test_abort();
        int dones;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.amt = 4'd8; bus.din = 16'h00FF;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_idle_regs("abort_reset");
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 2) reset_n = 1'b1;
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0 || bus.dout !== 16'h0000) begin
            errors++;
            $display("FAIL abort: done pulses %0d dout=%h, required 0 0000", dones, bus.dout);
        end
        last_dout = '0;
        run_op(2'b01, 4'd8, 16'h00FF, 16'hFF00, "rerun");
    endtask

    initial begin
        test_reset();
        test_left();
        test_arith_right();
        test_max_amt();
        test_zero_len();
        test_interference();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
